hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// parameter defaults and the stall/flush control bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam int unsigned MEM_TIMEOUT_DEF = 256;
  localparam int unsigned CNT_W_DEF       = 32;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  // Full freeze: hold every stage and drain MEM/WB with a NOP.
  function automatic ctrl_t freeze_ctrl();
    ctrl_t c;
    c               = '0;
    c.pc_stall      = 1'b1;
    c.if_id_stall   = 1'b1;
    c.id_ex_stall   = 1'b1;
    c.ex_mem_stall  = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: decode/execute/memory status in,
// stall/flush/bubble controls out.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       ex_mem_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_bubble;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_bubble
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_bubble
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-wait
// freeze with timeout to HALT, plus stall/flush performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  input  logic             perf_clr,
  output logic [1:0]       state,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_nxt;
  logic        r_err;
  logic        w_err_set;
  logic        w_load_use;
  logic        w_freeze;
  ctrl_t       w_ctrl;

  assign w_load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  assign w_freeze = ((r_state == RUN) && hz.mem_req && !hz.mem_ready) ||
                    ((r_state == MEM_WAIT) && !hz.mem_ready) ||
                    (r_state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= r_err | w_err_set;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait_cnt;
    w_err_set  = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          w_next     = MEM_WAIT;
          w_wait_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          w_next = RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next    = HALT;
          w_err_set = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + 16'd1;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = RUN;
    endcase
  end

  // Priority: freeze > branch flush > load-use bubble; all gated off in reset.
  always_comb begin
    w_ctrl = '0;
    if (rst_n) begin
      if (w_freeze) begin
        w_ctrl = freeze_ctrl();
      end else if (hz.ex_branch_taken) begin
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        w_ctrl.pc_stall    = 1'b1;
        w_ctrl.if_id_stall = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  assign hz.pc_stall      = w_ctrl.pc_stall;
  assign hz.if_id_stall   = w_ctrl.if_id_stall;
  assign hz.id_ex_stall   = w_ctrl.id_ex_stall;
  assign hz.ex_mem_stall  = w_ctrl.ex_mem_stall;
  assign hz.if_id_flush   = w_ctrl.if_id_flush;
  assign hz.id_ex_flush   = w_ctrl.id_ex_flush;
  assign hz.mem_wb_bubble = w_ctrl.mem_wb_bubble;

  assign state           = r_state;
  assign mem_timeout_err = r_err;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ctrl.pc_stall),
    .clr   (perf_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ctrl.if_id_flush),
    .clr   (perf_clr),
    .cnt   (flush_cnt)
  );

endmodule
